// File: rtl/rx_sonar_7o1.sv
// rx_sonar_7o1: 7O1 serial receiver with "AAA,DDD#" sonar frame parser
// Ports: clock, reset (sync, active-high); entrada_serial serial line (idle high);
//   angulo/distancia BCD of the last valid frame, pronto one-cycle update pulse;
//   erro_paridade/erro_quadro/erro_formato one-cycle error pulses;
//   db_dado last good character, db_estado parser index.
module rx_sonar_7o1 #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [6:0] SEP_CHAR     = 7'h2C,
    parameter logic [6:0] END_CHAR     = 7'h23
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] angulo,
    output logic [11:0] distancia,
    output logic        pronto,
    output logic        erro_paridade,
    output logic        erro_quadro,
    output logic        erro_formato,
    output logic [6:0]  db_dado,
    output logic [3:0]  db_estado
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_nx;

    logic         sync1, rx, armed, par_bit, char_ok;
    logic [W-1:0] cnt;
    logic [2:0]   bit_cnt, idx;
    logic [6:0]   shift, char_data;
    logic [11:0]  stage_a, stage_d;
    logic         half_done, full_done, stop_sample, par_ok, char_good, is_digit, accept;

    assign half_done   = cnt == HALF;
    assign full_done   = cnt == FULL;
    assign stop_sample = state == STOP && full_done;
    assign par_ok      = ^{shift, par_bit};
    assign char_good   = rx && par_ok;
    assign is_digit    = char_data >= 7'h30 && char_data <= 7'h39;
    assign accept      = idx == 3'd3 ? char_data == SEP_CHAR :
                         idx == 3'd7 ? char_data == END_CHAR : is_digit;
    assign db_estado   = {1'b0, idx};

    // armed blocks a new start after a framing error until the line has gone high again
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !rx && armed ? START : IDLE;
            START:   state_nx = half_done ? (rx ? IDLE : DATA) : START;
            DATA:    state_nx = full_done && bit_cnt == 3'd6 ? PARITY : DATA;
            PARITY:  state_nx = full_done ? STOP : PARITY;
            STOP:    state_nx = full_done ? IDLE : STOP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1         <= 1'b1;
            rx            <= 1'b1;
            armed         <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            par_bit       <= 1'b0;
            char_ok       <= 1'b0;
            char_data     <= '0;
            idx           <= '0;
            stage_a       <= '0;
            stage_d       <= '0;
            angulo        <= '0;
            distancia     <= '0;
            pronto        <= 1'b0;
            erro_paridade <= 1'b0;
            erro_quadro   <= 1'b0;
            erro_formato  <= 1'b0;
            db_dado       <= '0;
        end else begin
            sync1   <= entrada_serial;
            rx      <= sync1;
            armed   <= rx || (armed && !stop_sample);
            state   <= state_nx;
            cnt     <= state == IDLE || state_nx != state || full_done ? '0 : cnt + 1'b1;
            if (state == START && half_done)
                bit_cnt <= '0;
            if (state == DATA && full_done) begin
                shift   <= {rx, shift[6:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == PARITY && full_done)
                par_bit <= rx;
            // character strobe: a bad stop masks a bad parity
            char_ok       <= stop_sample && char_good;
            erro_quadro   <= stop_sample && !rx;
            erro_paridade <= stop_sample && rx && !par_ok;
            if (stop_sample)
                char_data <= shift;
            // discards flag in the strobe cycle, parser rejects one cycle later
            erro_formato  <= (stop_sample && !char_good) || (char_ok && !accept);
            pronto        <= char_ok && accept && idx == 3'd7;
            if (stop_sample && !char_good)
                idx <= '0;
            else if (char_ok)
                idx <= accept && idx != 3'd7 ? idx + 1'b1 : '0;
            if (char_ok)
                db_dado <= char_data;
            if (char_ok && accept) begin
                case (idx)
                    3'd0:    stage_a[11:8] <= char_data[3:0];
                    3'd1:    stage_a[7:4]  <= char_data[3:0];
                    3'd2:    stage_a[3:0]  <= char_data[3:0];
                    3'd4:    stage_d[11:8] <= char_data[3:0];
                    3'd5:    stage_d[7:4]  <= char_data[3:0];
                    3'd6:    stage_d[3:0]  <= char_data[3:0];
                    default: ;
                endcase
                if (idx == 3'd7) begin
                    angulo    <= stage_a;
                    distancia <= stage_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_rx_sonar_7o1.sv
// tb_rx_sonar_7o1: self-checking bench for the 7O1 sonar frame receiver
module tb_rx_sonar_7o1;
    localparam int CPB = 8;

    logic        clock = 1'b0, reset = 1'b1, entrada_serial = 1'b1;
    logic [11:0] angulo, distancia;
    logic        pronto, erro_paridade, erro_quadro, erro_formato;
    logic [6:0]  db_dado;
    logic [3:0]  db_estado;

    rx_sonar_7o1 #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .entrada_serial(entrada_serial),
        .angulo(angulo), .distancia(distancia), .pronto(pronto),
        .erro_paridade(erro_paridade), .erro_quadro(erro_quadro),
        .erro_formato(erro_formato), .db_dado(db_dado), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;
    int cyc = 0;
    int n_par, n_quad, n_fmt, n_pr, n_long, pronto_cyc;
    int e_par, e_quad, e_fmt, e_pr;
    logic [3:0] prev_p = '0;

    logic [6:0]  pbuf [8];
    int          plen = 0;
    logic [6:0]  last_good = '0;
    logic [11:0] m_ang = '0, m_dist = '0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (pronto) begin
            n_pr++;
            pronto_cyc = cyc;
        end
        n_par  += int'(erro_paridade);
        n_quad += int'(erro_quadro);
        n_fmt  += int'(erro_formato);
        if (|(prev_p & {pronto, erro_paridade, erro_quadro, erro_formato}))
            n_long++;
        prev_p = {pronto, erro_paridade, erro_quadro, erro_formato};
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_counts();
        n_par = 0; n_quad = 0; n_fmt = 0; n_pr = 0; n_long = 0;
        e_par = 0; e_quad = 0; e_fmt = 0; e_pr = 0;
    endtask

    task automatic drive_bit(input logic b);
        entrada_serial = b;
        repeat (CPB) @(posedge clock);
    endtask

    task automatic send_raw(input logic [6:0] ch, input bit bp, input bit bs);
        logic p;
        p = ~(^ch) ^ bp;
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(ch[i]);
        drive_bit(p);
        drive_bit(!bs);
        entrada_serial = 1'b1;
    endtask

    // reference: a frame is the pattern ddd,ddd# built from good characters only
    task automatic feed(input logic [6:0] ch, input bit bp, input bit bs);
        bit fits;
        if (bs) begin
            e_quad++; e_fmt++; plen = 0;
        end else if (bp) begin
            e_par++; e_fmt++; plen = 0;
        end else begin
            last_good = ch;
            fits = plen == 3 ? ch == 7'h2C : plen == 7 ? ch == 7'h23 : (ch >= 7'h30 && ch <= 7'h39);
            if (fits) begin
                pbuf[plen] = ch;
                plen++;
            end else begin
                e_fmt++;
                plen = 0;
            end
            if (plen == 8) begin
                m_ang  = {pbuf[0][3:0], pbuf[1][3:0], pbuf[2][3:0]};
                m_dist = {pbuf[4][3:0], pbuf[5][3:0], pbuf[6][3:0]};
                e_pr++;
                plen = 0;
            end
        end
        send_raw(ch, bp, bs);
        if (bs) repeat (2 * CPB) @(posedge clock);
    endtask

    task automatic send_str(input string s);
        byte b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            feed(b[6:0], 1'b0, 1'b0);
        end
    endtask

    task automatic settle();
        repeat (6) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({angulo, distancia} !== 24'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h/%h want 000/000", angulo, distancia);
        end
        checks++;
        if ({pronto, erro_paridade, erro_quadro, erro_formato} !== 4'b0) begin
            failures++;
            $display("FAIL reset_pulses: got %b want 0000", {pronto, erro_paridade, erro_quadro, erro_formato});
        end
        checks++;
        if ({db_dado, db_estado} !== 11'h0) begin
            failures++;
            $display("FAIL reset_debug: got dado=%h estado=%h want 0/0", db_dado, db_estado);
        end
        @(posedge clock);
        reset = 1'b0;
        repeat (4) @(posedge clock);
    endtask

    task automatic test_frame();
        int t0;
        clear_counts();
        send_str("045,123");
        t0 = cyc;
        feed(7'h23, 1'b0, 1'b0);
        settle();
        checks++;
        if (n_pr !== 1) begin
            failures++;
            $display("FAIL frame_pronto_count: got %0d want 1", n_pr);
        end
        checks++;
        if (pronto_cyc - t0 < 76 || pronto_cyc - t0 > 86) begin
            failures++;
            $display("FAIL frame_pronto_time: got %0d cycles after start of '#' want 76..86", pronto_cyc - t0);
        end
        checks++;
        if (angulo !== 12'h045 || angulo !== m_ang) begin
            failures++;
            $display("FAIL frame_angulo: got %h want 045", angulo);
        end
        checks++;
        if (distancia !== 12'h123 || distancia !== m_dist) begin
            failures++;
            $display("FAIL frame_distancia: got %h want 123", distancia);
        end
        checks++;
        if ({n_par, n_quad, n_fmt, n_long} !== {32'd0, 32'd0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL frame_errors: got par=%0d quad=%0d fmt=%0d long=%0d want 0", n_par, n_quad, n_fmt, n_long);
        end
        checks++;
        if (db_dado !== 7'h23) begin
            failures++;
            $display("FAIL frame_db_dado: got %h want 23", db_dado);
        end
    endtask

    task automatic test_parity();
        clear_counts();
        feed(7'h30, 1'b1, 1'b0);
        settle();
        checks++;
        if ({n_par, n_quad, n_fmt, n_pr} !== {32'd1, 32'd0, 32'd1, 32'd0}) begin
            failures++;
            $display("FAIL parity_pulses: got par=%0d quad=%0d fmt=%0d pr=%0d want 1/0/1/0", n_par, n_quad, n_fmt, n_pr);
        end
        checks++;
        if (db_estado !== 4'd0 || {angulo, distancia} !== 24'h045123) begin
            failures++;
            $display("FAIL parity_state: got estado=%0d out=%h/%h want 0 045/123", db_estado, angulo, distancia);
        end
    endtask

    task automatic test_frame_err();
        clear_counts();
        feed(7'h35, 1'b0, 1'b1);
        settle();
        checks++;
        if ({n_par, n_quad, n_fmt, n_pr, n_long} !== {32'd0, 32'd1, 32'd1, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL stop_pulses: got par=%0d quad=%0d fmt=%0d pr=%0d long=%0d want 0/1/1/0/0", n_par, n_quad, n_fmt, n_pr, n_long);
        end
        checks++;
        if (db_estado !== 4'd0) begin
            failures++;
            $display("FAIL stop_estado: got %0d want 0", db_estado);
        end
    endtask

    task automatic test_resync();
        clear_counts();
        send_str("04#090,010#");
        settle();
        checks++;
        if ({n_fmt, n_pr, n_par, n_quad} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL resync_pulses: got fmt=%0d pr=%0d par=%0d quad=%0d want 1/1/0/0", n_fmt, n_pr, n_par, n_quad);
        end
        checks++;
        if ({angulo, distancia} !== 24'h090010 || {angulo, distancia} !== {m_ang, m_dist}) begin
            failures++;
            $display("FAIL resync_outputs: got %h/%h want 090/010", angulo, distancia);
        end
    endtask

    task automatic test_bad_sep();
        clear_counts();
        send_str("045;123#");
        settle();
        checks++;
        if ({n_fmt, n_pr} !== {32'd2, 32'd0} || n_fmt !== e_fmt) begin
            failures++;
            $display("FAIL badsep_pulses: got fmt=%0d pr=%0d want 2/0", n_fmt, n_pr);
        end
        checks++;
        if ({angulo, distancia} !== 24'h090010 || db_estado !== 4'd0) begin
            failures++;
            $display("FAIL badsep_state: got %h/%h estado=%0d want 090/010 0", angulo, distancia, db_estado);
        end
    endtask

    task automatic test_glitch();
        clear_counts();
        entrada_serial = 1'b0;
        repeat (3) @(posedge clock);
        entrada_serial = 1'b1;
        repeat (3 * CPB) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({n_par, n_quad, n_fmt, n_pr} !== {32'd0, 32'd0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL glitch_pulses: got par=%0d quad=%0d fmt=%0d pr=%0d want 0", n_par, n_quad, n_fmt, n_pr);
        end
        feed(7'h31, 1'b0, 1'b0);
        settle();
        checks++;
        if (db_estado !== 4'(plen) || db_dado !== 7'h31 || n_fmt !== 0) begin
            failures++;
            $display("FAIL glitch_recover: got estado=%0d dado=%h fmt=%0d want %0d 31 0", db_estado, db_dado, n_fmt, plen);
        end
    endtask

    task automatic test_break();
        clear_counts();
        entrada_serial = 1'b0;
        repeat (12 * CPB) @(posedge clock);
        entrada_serial = 1'b1;
        repeat (3 * CPB) @(posedge clock);
        @(negedge clock);
        plen = 0;
        checks++;
        if ({n_quad, n_fmt, n_par, n_pr, n_long} !== {32'd1, 32'd1, 32'd0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL break_pulses: got quad=%0d fmt=%0d par=%0d pr=%0d long=%0d want 1/1/0/0/0", n_quad, n_fmt, n_par, n_pr, n_long);
        end
        checks++;
        if (db_estado !== 4'd0) begin
            failures++;
            $display("FAIL break_estado: got %0d want 0", db_estado);
        end
    endtask

    task automatic test_reset_mid();
        send_str("180,2");
        clear_counts();
        fork
            send_raw(7'h30, 1'b0, 1'b0);
            begin
                repeat (30) @(posedge clock);
                reset = 1'b1;
            end
        join
        repeat (3) @(posedge clock);
        reset = 1'b0;
        plen = 0; m_ang = '0; m_dist = '0; last_good = '0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({n_par, n_quad, n_fmt, n_pr} !== {32'd0, 32'd0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL midreset_pulses: got par=%0d quad=%0d fmt=%0d pr=%0d want 0", n_par, n_quad, n_fmt, n_pr);
        end
        checks++;
        if ({angulo, distancia, db_estado} !== 28'h0) begin
            failures++;
            $display("FAIL midreset_state: got %h/%h estado=%0d want 0", angulo, distancia, db_estado);
        end
        send_str("180,200#");
        settle();
        checks++;
        if (n_pr !== 1 || {angulo, distancia} !== 24'h180200) begin
            failures++;
            $display("FAIL midreset_frame: got pr=%0d out=%h/%h want 1 180/200", n_pr, angulo, distancia);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ch;
        int r;
        clear_counts();
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 8; k++) begin
                ch = k == 3 ? 7'h2C : k == 7 ? 7'h23 : 7'(7'h30 + $urandom_range(0, 9));
                r = $urandom_range(0, 23);
                if (r == 2) ch = 7'($urandom_range(0, 127));
                feed(ch, r == 0, r == 1);
            end
        end
        settle();
        checks++;
        if ({n_par, n_quad, n_fmt, n_pr} !== {e_par, e_quad, e_fmt, e_pr}) begin
            failures++;
            $display("FAIL b2b_pulses: got par=%0d quad=%0d fmt=%0d pr=%0d want %0d/%0d/%0d/%0d", n_par, n_quad, n_fmt, n_pr, e_par, e_quad, e_fmt, e_pr);
        end
        checks++;
        if ({angulo, distancia} !== {m_ang, m_dist}) begin
            failures++;
            $display("FAIL b2b_outputs: got %h/%h want %h/%h", angulo, distancia, m_ang, m_dist);
        end
        checks++;
        if (db_estado !== 4'(plen) || db_dado !== last_good) begin
            failures++;
            $display("FAIL b2b_debug: got estado=%0d dado=%h want %0d %h", db_estado, db_dado, plen, last_good);
        end
        checks++;
        if (n_long !== 0) begin
            failures++;
            $display("FAIL b2b_pulse_width: got %0d long pulses want 0", n_long);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_parity();
        test_frame_err();
        test_resync();
        test_bad_sep();
        test_glitch();
        test_break();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_sonar_7o1.md
Name: rx_sonar_7O1

Overview:
- Receiving end of the sonar serial link. Deserialises 7O1 asynchronous characters: 1 start bit, 7 data bits LSB first, odd parity, 1 stop bit.
- Parses the sonar frame "AAA,DDD#": three angle digits, ',', three distance digits, '#'.
- Presents angle and distance as 3-digit BCD with a one-cycle pronto pulse.
- Sits on the host/monitor FPGA side, or in a loopback bench against the sonar transmitter.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); minimum 4.
- SEP_CHAR, 7'h2C, ASCII separator between angle and distance (',').
- END_CHAR, 7'h23, ASCII frame terminator ('#').

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- entrada_serial  input  1  serial line, idle high
- angulo  output  12  BCD angle {centena,dezena,unidade} of last valid frame
- distancia  output  12  BCD distance {centena,dezena,unidade} of last valid frame
- pronto  output  1  one-cycle pulse when angulo/distancia update
- erro_paridade  output  1  one-cycle pulse, character with bad parity
- erro_quadro  output  1  one-cycle pulse, stop bit sampled low
- erro_formato  output  1  one-cycle pulse, unexpected character in frame
- db_dado  output  7  last received character (debug)
- db_estado  output  4  frame parser state (debug)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: angulo=0, distancia=0, pronto=0, all erro_*=0, db_dado=0, db_estado=0. Receiver returns to IDLE and the parser to index 0.
- Input path: two-flop synchroniser on entrada_serial, which adds 2 cycles of latency. The synchroniser resets to 1.
- Bit receiver FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronised low level.
  - START: count CLKS_PER_BIT/2 (integer division). If the line is still low, load the bit counter and go to DATA. If high, treat it as a glitch and return to IDLE with no pulse.
  - DATA: sample every CLKS_PER_BIT cycles at bit centre, 7 samples, shifting LSB first.
  - PARITY: sample one bit. Parity is good when XOR of the 7 data bits and the parity bit equals 1.
  - STOP: sample one bit. Go to IDLE immediately, without waiting out the rest of the stop bit, so back-to-back characters are caught.
- Character strobe: asserted for one cycle in the cycle after the stop sample.
  - Stop sample 0: erro_quadro pulses and the character is discarded (not passed to the parser).
  - Parity bad and stop good: erro_paridade pulses and the character is discarded.
  - Both bad: only erro_quadro pulses.
  - Good character: db_dado updates and the character is passed to the parser.
- Any discarded character also resets the parser index to 0 and pulses erro_formato in the same cycle.
- Frame parser: index 0..7, reported on db_estado.
  - Index 0-2 and 4-6 accept ASCII '0'..'9' (7'h30..7'h39). Store the low nibble into the angle or distance digit, centena first.
  - Index 3 accepts SEP_CHAR only.
  - Index 7 accepts END_CHAR only. On accept: angulo and distancia load from the staging registers, pronto pulses one cycle later (two cycles after the stop sample), and index returns to 0.
  - Any other character at any index: erro_formato pulses and index goes to 0.
  - Exception: an END_CHAR received at an index other than 7 also resets to index 0 with erro_formato. This resynchronises on the next frame.
- Staging registers are separate from angulo/distancia, so a partial or aborted frame never alters the outputs.
- Reset asserted mid-character or mid-frame: everything is abandoned, with no pulses. Because the receiver restarts in IDLE, a following low data bit can mis-trigger; the parser rejects the result via format checks.
- Line held low (break): yields a character with erro_quadro. No new start is detected until the line has returned high.

Test Plan:
- CLKS_PER_BIT=8; send "045,123#" with correct parity -> pronto pulses once, 2 cycles after the '#' stop sample; angulo=12'h045, distancia=12'h123; no erro_* pulses.
- Send '0' (7'h30) with the parity bit inverted -> erro_paridade=1 and erro_formato=1 for one cycle; db_estado=0; outputs keep the previous frame.
- Send '5' with stop bit 0 -> erro_quadro=1 only (erro_paridade=0); parser index=0.
- Send "04" then "#" then "090,010#" -> erro_formato pulses on '#'; the next frame is valid: angulo=12'h090, distancia=12'h010.
- Send "045;123#" -> erro_formato at ';'; the subsequent '1','2','3' are parsed from index 0; the final '#' at index 3 flags erro_formato; pronto never asserts.
- 3-cycle low glitch on an idle line -> no pulses, receiver back in IDLE. Reset asserted during the distance digits, then a full "180,200#" -> pronto with angulo=12'h180, distancia=12'h200.
